// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD up/down counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Saturate a nibble into the legal decimal range 0..9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit register with increment/decrement, carry/borrow chaining and clamped load.
// Latency: 1 CLK from cin/bin/load to the new digit; cout/bout are combinational from the register.
// Backpressure: none; a step happens only when cin or bin is asserted by the previous stage.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       cin,
  input  logic       bin,
  output logic       cout,
  output logic       bout,
  output logic [3:0] digit
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Load wins over stepping; the >= compare keeps any stray value on the wrap path.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(load_val);
    end else if (cin) begin
      digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
    end else if (bin) begin
      digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  // Digit state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  // Carry/borrow pass on only when this digit wraps, so the chain ripples in one cycle.
  assign cout  = cin & (digit_q >= BCD_MAX);
  assign bout  = bin & (digit_q == BCD_MIN);
  assign digit = digit_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with a free-running prescaler enable and terminal-count pulse.
// Latency: COUNT shows a step 1 CLK after the TICK cycle; LOAD visible 1 CLK after the strobe; TC registered.
// Backpressure: none; EN gates stepping and is only sampled in the TICK cycle.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned DIV_WIDTH  = 23,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic                  TICK,
  output logic                  TC
);

  logic [DIV_WIDTH-1:0] prescaler_q;
  logic [DIV_WIDTH-1:0] prescaler_d;
  logic                 tc_q;
  logic                 tc_d;
  logic                 step;
  logic [DIGITS:0]      carry;
  logic [DIGITS:0]      borrow;
  logic [4*DIGITS-1:0]  digits;

  // TICK marks the last cycle of each prescaler period.
  assign TICK = &prescaler_q;

  // A count step needs the tick and enable, and is suppressed by a coincident load.
  assign step      = TICK & EN & ~LOAD;
  assign carry[0]  = step & UP;
  assign borrow[0] = step & ~UP;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (LOAD),
        .load_val (LOAD_VAL[4*gi +: 4]),
        .cin      (carry[gi]),
        .bin      (borrow[gi]),
        .cout     (carry[gi+1]),
        .bout     (borrow[gi+1]),
        .digit    (digits[4*gi +: 4])
      );
    end
  endgenerate

  // Load restarts the period so a full interval elapses before the next step.
  always_comb begin
    prescaler_d = prescaler_q + DIV_WIDTH'(1);
    if (LOAD) begin
      prescaler_d = '0;
    end
  end

  // A carry or borrow leaving the top digit means the whole counter wrapped.
  always_comb begin
    tc_d = carry[DIGITS] | borrow[DIGITS];
  end

  // Prescaler and terminal-count registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prescaler_q <= '0;
      tc_q        <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      tc_q        <= tc_d;
    end
  end

  assign TC    = tc_q;
  assign COUNT = ACTIVE_LOW ? ~digits : digits;

endmodule
